// File: rtl/quant_gray_pipe.sv
// Three-stage colour quantiser: bypass, average gray, luma gray or posterise to 2^QBITS levels.
// Optional 4x4 ordered dither before quantisation when QGRAY_DITHER_EN is defined.
module quant_gray_pipe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned QBITS  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_mode,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_sof,
    input  logic              i_eol,
    input  logic [DATA_W-1:0] iRed,
    input  logic [DATA_W-1:0] iGreen,
    input  logic [DATA_W-1:0] iBlue,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sof,
    output logic              o_eol,
    output logic [DATA_W-1:0] oRed,
    output logic [DATA_W-1:0] oGreen,
    output logic [DATA_W-1:0] oBlue
);

    localparam int unsigned LSB_W = DATA_W - QBITS;
    localparam int unsigned SUM_W = DATA_W + 2;
    localparam int unsigned ACC_W = DATA_W + 8;
    localparam logic [DATA_W-1:0] QMASK = DATA_W'({DATA_W{1'b1}} << LSB_W);

    localparam logic [1:0] MODE_BYP  = 2'd0;
    localparam logic [1:0] MODE_AVG  = 2'd1;
    localparam logic [1:0] MODE_LUMA = 2'd2;
    localparam logic [1:0] MODE_POST = 2'd3;

    logic              en;
    logic              accept;

    logic              s1_valid, s1_sof, s1_eol;
    logic [1:0]        s1_mode;
    logic [DATA_W-1:0] s1_red, s1_green, s1_blue;
    logic [ACC_W-1:0]  s1_acc;

    logic              s2_valid, s2_sof, s2_eol;
    logic [1:0]        s2_mode;
    logic [DATA_W-1:0] s2_red, s2_green, s2_blue;
    logic [DATA_W-1:0] s2_gray;

    logic [ACC_W-1:0]  acc_c;
    logic [DATA_W-1:0] gray_c;
    logic [DATA_W-1:0] gray_s, red_s, green_s, blue_s;
    logic [DATA_W-1:0] red_c, green_c, blue_c;

    // Whole pipe moves together whenever the output slot is free or being taken.
    assign en      = !o_valid || i_ready;
    assign o_ready = en && !i_rst;
    assign accept  = i_valid && o_ready;

    // Stage 1 arithmetic: channel sum for average gray, weighted sum for luma.
    always_comb begin
        acc_c = ACC_W'(SUM_W'(iRed) + SUM_W'(iGreen) + SUM_W'(iBlue));
        if (i_mode == MODE_LUMA) begin
            acc_c = ACC_W'(77)  * ACC_W'(iRed)
                  + ACC_W'(150) * ACC_W'(iGreen)
                  + ACC_W'(29)  * ACC_W'(iBlue);
        end
    end

    // Stage 2 arithmetic: both results fit in DATA_W bits by construction.
    always_comb begin
        gray_c = DATA_W'(s1_acc >> 8);
        if (s1_mode == MODE_AVG) begin
            gray_c = DATA_W'(SUM_W'(s1_acc) / SUM_W'(3));
        end
    end

`ifdef QGRAY_DITHER_EN
    localparam int unsigned DSHL = (LSB_W >= 4) ? LSB_W - 4 : 0;
    localparam int unsigned DSHR = (LSB_W >= 4) ? 0 : 4 - LSB_W;

    logic [1:0]        col, row;
    logic [1:0]        px, py;
    logic [DATA_W-1:0] dith_c, s1_dith, s2_dith;

    function automatic logic [3:0] bayer(input logic [1:0] y, input logic [1:0] x);
        logic [3:0] b;
        case ({y, x})
            4'd0:  b = 4'd0;
            4'd1:  b = 4'd8;
            4'd2:  b = 4'd2;
            4'd3:  b = 4'd10;
            4'd4:  b = 4'd12;
            4'd5:  b = 4'd4;
            4'd6:  b = 4'd14;
            4'd7:  b = 4'd6;
            4'd8:  b = 4'd3;
            4'd9:  b = 4'd11;
            4'd10: b = 4'd1;
            4'd11: b = 4'd9;
            4'd12: b = 4'd15;
            4'd13: b = 4'd7;
            4'd14: b = 4'd13;
            default: b = 4'd5;
        endcase
        return b;
    endfunction

    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] d);
        logic [DATA_W:0] s;
        s = {1'b0, x} + {1'b0, d};
        return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
    endfunction

    // Raster position of the pixel being offered; i_sof restarts the frame.
    assign px     = i_sof ? 2'd0 : col;
    assign py     = i_sof ? 2'd0 : row;
    assign dith_c = DATA_W'(((DATA_W + 4)'(bayer(py, px)) << DSHL) >> DSHR);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col <= 2'd0;
            row <= 2'd0;
        end else if (accept) begin
            if (i_eol) begin
                col <= 2'd0;
                row <= py + 2'd1;
            end else begin
                col <= px + 2'd1;
                row <= py;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (en && !i_rst) begin
            s1_dith <= dith_c;
            s2_dith <= s1_dith;
        end
    end

    always_comb begin
        gray_s  = sat_add(s2_gray,  s2_dith);
        red_s   = sat_add(s2_red,   s2_dith);
        green_s = sat_add(s2_green, s2_dith);
        blue_s  = sat_add(s2_blue,  s2_dith);
    end
`else
    always_comb begin
        gray_s  = s2_gray;
        red_s   = s2_red;
        green_s = s2_green;
        blue_s  = s2_blue;
    end
`endif

    // Stage 3 selection and quantisation (keep top QBITS of each channel).
    always_comb begin
        red_c   = s2_red;
        green_c = s2_green;
        blue_c  = s2_blue;
        case (s2_mode)
            MODE_AVG, MODE_LUMA: begin
                red_c   = gray_s & QMASK;
                green_c = gray_s & QMASK;
                blue_c  = gray_s & QMASK;
            end
            MODE_POST: begin
                red_c   = red_s   & QMASK;
                green_c = green_s & QMASK;
                blue_c  = blue_s  & QMASK;
            end
            MODE_BYP: ;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_eol   <= 1'b0;
            o_valid  <= 1'b0;
            o_sof    <= 1'b0;
            o_eol    <= 1'b0;
            oRed     <= '0;
            oGreen   <= '0;
            oBlue    <= '0;
        end else if (en) begin
            s1_valid <= i_valid;
            s1_sof   <= i_valid && i_sof;
            s1_eol   <= i_valid && i_eol;
            s1_mode  <= i_mode;
            s1_red   <= iRed;
            s1_green <= iGreen;
            s1_blue  <= iBlue;
            s1_acc   <= acc_c;

            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_eol   <= s1_eol;
            s2_mode  <= s1_mode;
            s2_red   <= s1_red;
            s2_green <= s1_green;
            s2_blue  <= s1_blue;
            s2_gray  <= gray_c;

            o_valid  <= s2_valid;
            o_sof    <= s2_sof;
            o_eol    <= s2_eol;
            oRed     <= red_c;
            oGreen   <= green_c;
            oBlue    <= blue_c;
        end
    end

endmodule
